// File: rtl/input_fifo_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : input_fifo_buffer_pkg
//  Brief    : Shared sizing defaults for the input FIFO, the input read
//             controller and the consumer stage.
//  Revision : 1.0  initial release
// ============================================================================
package input_fifo_buffer_pkg;

    // Width of one stored word
    localparam int DEFAULT_DATA_WIDTH = 16;
    // Number of FIFO entries (power of two, at least 2)
    localparam int DEFAULT_DEPTH      = 8;
    // log2(DEFAULT_DEPTH)
    localparam int DEFAULT_ADDR_WIDTH = 3;

    // True when v is a power of two that is at least 2
    function automatic bit is_valid_depth(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage : input_fifo_buffer_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_mem
//  Brief    : DEPTH x DATA_WIDTH register array with one synchronous write
//             port and one synchronous (registered) read port. The array is
//             never reset; only the read register is.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_mem
    import input_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: stored contents survive reset, the pointers make them stale
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: output register holds its value unless a read is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : fifo_mem
`default_nettype wire

// File: rtl/input_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : input_fifo_buffer
//  Brief    : Single-clock circular FIFO between the input read controller
//             and the downstream consumer. One-cycle registered read, no
//             write-to-read bypass, sticky overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module input_fifo_buffer
    import input_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Elaboration-time sanity check on the sizing parameters
    generate
        if (!is_valid_depth(DEPTH) || (DEPTH != (1 << ADDR_WIDTH))) begin : g_bad_params
            $error("input_fifo_buffer: DEPTH must be a power of two >= 2 equal to 2**ADDR_WIDTH");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] wp;
    logic [ADDR_WIDTH-1:0] rp;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags derive only from occupancy, so they follow reset immediately
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Accept qualifiers: an empty FIFO never reads the word being written
    // in the same cycle, and a full FIFO frees its slot only after the edge
    assign wr_ok = wen && !full;
    assign rd_ok = ren && !empty;

    // Write pointer advances on every accepted write, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
        end else if (wr_ok) begin
            wp <= wp + 1'b1;
        end
    end

    // Read pointer advances on every accepted read, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp <= '0;
        end else if (rd_ok) begin
            rp <= rp + 1'b1;
        end
    end

    // Occupancy: balanced when both or neither transfer happens
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (wr_ok && !rd_ok) begin
            count <= count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count <= count - 1'b1;
        end
    end

    // Read data is valid for exactly the cycle after an accepted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_ok;
        end
    end

    // Overflow is sticky until reset: any write attempt while full sets it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wen && full) begin
            overflow <= 1'b1;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wp),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rp),
        .rdata (dout)
    );

endmodule : input_fifo_buffer
`default_nettype wire

// File: tb/tb_input_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_fifo_buffer
//  Brief    : Directed self-checking bench for input_fifo_buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_fifo_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [15:0] din;
    logic        full;
    logic        ren;
    logic [15:0] dout;
    logic        dout_valid;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    input_fifo_buffer #(
        .DATA_WIDTH (16),
        .DEPTH      (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .din        (din),
        .full       (full),
        .ren        (ren),
        .dout       (dout),
        .dout_valid (dout_valid),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns so outputs are sampled off-edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse, released away from the clock edge
    task automatic do_reset();
        wen = 1'b0;
        ren = 1'b0;
        din = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wen = 1'b0;
        ren = 1'b0;
        din = '0;
        rst = 1'b1;
        #2;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count actual=%0d required=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty actual=%b required=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full actual=%b required=0", full); end
        total++; if (dout !== 16'h0000) begin bad++; $display("FAIL reset_dout actual=%h required=0000", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid actual=%b required=0", dout_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow actual=%b required=0", overflow); end
        tick();
        rst = 1'b0;
    endtask

    // Eight writes 0x0001..0x0008 fill the FIFO
    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            wen = 1'b1;
            din = 16'(i);
            tick();
            total++; if (count !== 4'(i)) begin bad++; $display("FAIL fill_count[%0d] actual=%0d required=%0d", i, count, i); end
        end
        wen = 1'b0;
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full actual=%b required=1", full); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty actual=%b required=0", empty); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_overflow actual=%b required=0", overflow); end
    endtask

    // Write while full sets overflow; draining returns the original words
    task automatic test_overflow_drain();
        wen = 1'b1;
        din = 16'hFFFF;
        tick();
        wen = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag actual=%b required=1", overflow); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count actual=%0d required=8", count); end
        ren = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] actual=%b required=1", i, dout_valid); end
            total++; if (dout !== 16'(i)) begin bad++; $display("FAIL drain_dout[%0d] actual=%h required=%h", i, dout, 16'(i)); end
        end
        ren = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty actual=%b required=1", empty); end
        tick();
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL idle_valid actual=%b required=0", dout_valid); end
        total++; if (dout !== 16'h0008) begin bad++; $display("FAIL idle_dout_hold actual=%h required=0008", dout); end
        // read request while empty is ignored
        ren = 1'b1;
        tick();
        ren = 1'b0;
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL empty_read_valid actual=%b required=0", dout_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL empty_read_count actual=%0d required=0", count); end
        total++; if (dout !== 16'h0008) begin bad++; $display("FAIL empty_read_dout actual=%h required=0008", dout); end
    endtask

    // Simultaneous write and read on an empty FIFO: no bypass
    task automatic test_simul_empty();
        wen = 1'b1;
        ren = 1'b1;
        din = 16'h00AA;
        tick();
        wen = 1'b0;
        ren = 1'b0;
        total++; if (count !== 4'd1) begin bad++; $display("FAIL se_count actual=%0d required=1", count); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL se_valid actual=%b required=0", dout_valid); end
        ren = 1'b1;
        tick();
        ren = 1'b0;
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL se_read_valid actual=%b required=1", dout_valid); end
        total++; if (dout !== 16'h00AA) begin bad++; $display("FAIL se_read_dout actual=%h required=00AA", dout); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL se_read_count actual=%0d required=0", count); end
    endtask

    // Occupancy 4, 20 cycles of write+read: order kept across pointer wraps
    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            wen = 1'b1;
            din = 16'h0100 + 16'(i);
            tick();
        end
        total++; if (count !== 4'd4) begin bad++; $display("FAIL b2b_prefill actual=%0d required=4", count); end
        ren = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 16'h0104 + 16'(k);
            tick();
            total++; if (count !== 4'd4) begin bad++; $display("FAIL b2b_count[%0d] actual=%0d required=4", k, count); end
            total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] actual=%b required=1", k, dout_valid); end
            total++; if (dout !== 16'h0100 + 16'(k)) begin bad++; $display("FAIL b2b_dout[%0d] actual=%h required=%h", k, dout, 16'h0100 + 16'(k)); end
        end
        wen = 1'b0;
        for (int k = 20; k < 24; k++) begin
            tick();
            total++; if (dout !== 16'h0100 + 16'(k)) begin bad++; $display("FAIL b2b_tail[%0d] actual=%h required=%h", k, dout, 16'h0100 + 16'(k)); end
        end
        ren = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty actual=%b required=1", empty); end
    endtask

    // Full FIFO, write+read: oldest word out, write dropped, overflow set
    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wen = 1'b1;
            din = 16'h0200 + 16'(i);
            tick();
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fs_pre_overflow actual=%b required=0", overflow); end
        ren = 1'b1;
        din = 16'h02FF;
        tick();
        wen = 1'b0;
        total++; if (dout !== 16'h0200) begin bad++; $display("FAIL fs_dout actual=%h required=0200", dout); end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL fs_valid actual=%b required=1", dout_valid); end
        total++; if (count !== 4'd7) begin bad++; $display("FAIL fs_count actual=%0d required=7", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fs_overflow actual=%b required=1", overflow); end
        for (int i = 1; i < 8; i++) begin
            tick();
            total++; if (dout !== 16'h0200 + 16'(i)) begin bad++; $display("FAIL fs_drain[%0d] actual=%h required=%h", i, dout, 16'h0200 + 16'(i)); end
        end
        ren = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fs_empty actual=%b required=1", empty); end
    endtask

    // Reset asserted mid-cycle at occupancy 5 clears state before the next edge
    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wen = 1'b1;
            din = 16'h0300 + 16'(i);
            tick();
        end
        wen = 1'b0;
        ren = 1'b1;
        tick();
        ren = 1'b0;
        total++; if (count !== 4'd5) begin bad++; $display("FAIL rm_pre_count actual=%0d required=5", count); end
        total++; if (dout !== 16'h0300) begin bad++; $display("FAIL rm_pre_dout actual=%h required=0300", dout); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rm_count actual=%0d required=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rm_empty actual=%b required=1", empty); end
        total++; if (dout !== 16'h0000) begin bad++; $display("FAIL rm_dout actual=%h required=0000", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rm_valid actual=%b required=0", dout_valid); end
        // strobes during reset have no effect
        wen = 1'b1;
        ren = 1'b1;
        din = 16'h0BAD;
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rm_hold_count actual=%0d required=0", count); end
        wen = 1'b0;
        ren = 1'b0;
        rst = 1'b0;
        #2;
        ren = 1'b1;
        tick();
        ren = 1'b0;
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rm_post_valid actual=%b required=0", dout_valid); end
        total++; if (dout !== 16'h0000) begin bad++; $display("FAIL rm_post_dout actual=%h required=0000", dout); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rm_post_count actual=%0d required=0", count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_simul_empty();
        test_back_to_back();
        test_full_simul();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule : tb_input_fifo_buffer
`default_nettype wire

// File: doc/input_fifo_buffer.md
INPUT_FIFO_BUFFER -- requirements
Module: input_fifo_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one stored word.
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter ADDR_WIDTH, default 3, log2(DEPTH).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wen  input  1  write strobe from input read controller; one word per cycle high.
REQ-007 din  input  DATA_WIDTH  write data, sampled when wen high.
REQ-008 full  output  1  no free entry; fed back to input read controller.
REQ-009 ren  input  1  read request from downstream consumer.
REQ-010 dout  output  DATA_WIDTH  registered read data.
REQ-011 dout_valid  output  1  dout holds a word popped in the previous cycle.
REQ-012 empty  output  1  no stored entry.
REQ-013 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-014 overflow  output  1  sticky: a write was attempted while full.

Function
REQ-015 Storage SHALL be circular, with write pointer wp and read pointer rp, each ADDR_WIDTH bits, wrapping DEPTH-1 -> 0.
REQ-016 Write accepted iff wen && !full: mem[wp] <= din, wp <= wp+1.
REQ-017 Read accepted iff ren && !empty: dout <= mem[rp], rp <= rp+1; dout_valid high the following cycle only.
REQ-018 Read latency SHALL be exactly 1 cycle from accepted ren to dout_valid.
REQ-019 dout SHALL hold its last value when no read is accepted; dout_valid low in that case.
REQ-020 count: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 full = (count == DEPTH); empty = (count == 0); both combinational from count.
REQ-022 Simultaneous wen and ren, 0<count<DEPTH: both accepted, count unchanged.
REQ-023 Simultaneous wen and ren while empty: write accepted, read ignored (no bypass); count -> 1.
REQ-024 Simultaneous wen and ren while full: read accepted, write rejected; overflow set; count -> DEPTH-1.
REQ-025 wen while full SHALL not modify mem or wp; overflow <= 1 and stays set until rst.
REQ-026 ren while empty SHALL not modify rp, count or dout; dout_valid low next cycle.
REQ-027 Data SHALL emerge in write order across any number of pointer wraps.

Reset
REQ-028 rst high SHALL immediately clear wp, rp, count, dout, dout_valid and overflow; full=0, empty=1.
REQ-029 mem contents are not cleared; a reset mid-operation discards all stored words.
REQ-030 wen/ren asserted during rst SHALL have no effect.

Structure
REQ-031 Shared defines header holds DATA_WIDTH/DEPTH defaults, shared with input_read_controller and the consumer stage.
REQ-032 One sub-module fifo_mem: DEPTH x DATA_WIDTH register array, one synchronous write port, one synchronous read port; pointers, count and flags stay in input_fifo_buffer.

Verification
REQ-033 rst, then 8 writes 0x0001..0x0008 -> full=1 after 8th, count=8, empty=0, overflow=0.
REQ-034 From full, wen with din=0xFFFF -> overflow=1, count=8; 8 reads return 0x0001..0x0008, each dout_valid 1 cycle after ren, then empty=1.
REQ-035 Empty FIFO, wen+ren same cycle, din=0x00AA -> count=1, dout_valid=0 next cycle; next ren -> dout=0x00AA.
REQ-036 Count=4, wen+ren for 20 consecutive cycles with an incrementing din -> count stays 4, output order preserved across pointer wraps.
REQ-037 Full FIFO, wen+ren same cycle -> oldest word read, count=7, overflow=1.
REQ-038 Count=5, assert rst mid-cycle -> count=0, empty=1, dout=0, dout_valid=0 before the next edge; subsequent ren with rst low gives dout_valid=0.
